// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus bundled for apb_master.
// The master modport is the DUT's view; slave is the requester/peripheral side.
interface apb_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_slverr;
   logic        rsp_timeout;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
             psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
             psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: turns one command into a SETUP/ACCESS transfer
// and returns a one-cycle response, with optional ACCESS-phase timeout.
module apb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic            pclk,
   input  logic            presetn,
   apb_master_if.master    bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_e;

   localparam bit          TO_ENABLE = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TO_LAST   = TO_ENABLE ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

   state_e      state_q, state_d;
   logic        psel_q, psel_d;
   logic        penable_q, penable_d;
   logic        pwrite_q, pwrite_d;
   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_slverr_q, rsp_slverr_d;
   logic        rsp_timeout_q, rsp_timeout_d;
   logic [31:0] wait_q, wait_d;

   // NOTE: every output is assigned its hold value first, so no path leaves a latch.
   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_slverr_d  = rsp_slverr_q;
      rsp_timeout_d = rsp_timeout_q;
      wait_d        = wait_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               if (bus.cmd_addr[1:0] == 2'b00) begin
                  state_d   = S_SETUP;
                  psel_d    = 1'b1;
                  penable_d = 1'b0;
                  pwrite_d  = bus.cmd_write;
                  paddr_d   = bus.cmd_addr;
                  pwdata_d  = bus.cmd_write ? bus.cmd_wdata : 32'd0;
               end else begin
                  // Misaligned requests are rejected locally without touching the bus.
                  rsp_valid_d   = 1'b1;
                  rsp_rdata_d   = 32'd0;
                  rsp_slverr_d  = 1'b1;
                  rsp_timeout_d = 1'b0;
               end
            end
         end

         S_SETUP: begin
            state_d   = S_ACCESS;
            penable_d = 1'b1;
            wait_d    = 32'd0;
         end

         S_ACCESS: begin
            if (bus.pready) begin
               state_d       = S_IDLE;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = pwrite_q ? 32'd0 : bus.prdata;
               rsp_slverr_d  = bus.pslverr;
               rsp_timeout_d = 1'b0;
            end else if (TO_ENABLE && (wait_q == TO_LAST)) begin
               state_d       = S_IDLE;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = 32'd0;
               rsp_slverr_d  = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + 32'd1;
            end
         end

         default: begin
            state_d   = S_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q       <= S_IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= 32'd0;
         pwdata_q      <= 32'd0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= 32'd0;
         rsp_slverr_q  <= 1'b0;
         rsp_timeout_q <= 1'b0;
         wait_q        <= 32'd0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_slverr_q  <= rsp_slverr_d;
         rsp_timeout_q <= rsp_timeout_d;
         wait_q        <= wait_d;
      end
   end

   assign bus.cmd_ready   = (state_q == S_IDLE);
   assign bus.psel        = psel_q;
   assign bus.penable     = penable_q;
   assign bus.pwrite      = pwrite_q;
   assign bus.paddr       = paddr_q;
   assign bus.pwdata      = pwdata_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_slverr  = rsp_slverr_q;
   assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares each rsp_valid pulse.
module tb_apb_master;

   typedef struct packed {
      logic [31:0] rdata;
      logic        slverr;
      logic        timeout;
   } rsp_t;

   logic pclk;
   logic presetn;
   apb_master_if bus_if ();

   apb_master #(.TIMEOUT_CYCLES(4)) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus_if.master)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int   errors = 0;
   int   checks = 0;
   int   rsp_seen = 0;
   int   rsp_expected = 0;
   rsp_t sb_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
      end
   endtask

   // Monitor: every rsp_valid pulse must match the oldest queued expectation.
   always @(negedge pclk) begin
      if (bus_if.rsp_valid === 1'b1) begin
         rsp_t exp;
         rsp_seen++;
         if (sb_q.size() == 0) begin
            check("unexpected_rsp_valid", 32'd1, 32'd0);
         end else begin
            exp = sb_q.pop_front();
            check("rsp_rdata",   bus_if.rsp_rdata,          exp.rdata);
            check("rsp_slverr",  32'(bus_if.rsp_slverr),    32'(exp.slverr));
            check("rsp_timeout", 32'(bus_if.rsp_timeout),   32'(exp.timeout));
         end
      end
   end

   // Caller must be at a negedge with the DUT idle; returns at the negedge the response is visible.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input logic err, input logic [31:0] rd,
                       input logic never_ready);
      rsp_t exp;
      int   acc_cycles;
      check("cmd_ready_idle", 32'(bus_if.cmd_ready), 32'd1);
      check("psel_gap", 32'(bus_if.psel), 32'd0);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_write = wr;
      bus_if.cmd_addr  = addr;
      bus_if.cmd_wdata = wdata;
      if (addr[1:0] != 2'b00)  exp = '{rdata: 32'd0, slverr: 1'b1, timeout: 1'b0};
      else if (never_ready)    exp = '{rdata: 32'd0, slverr: 1'b1, timeout: 1'b1};
      else                     exp = '{rdata: (wr ? 32'd0 : rd), slverr: err, timeout: 1'b0};
      sb_q.push_back(exp);
      rsp_expected++;
      @(negedge pclk);
      // Scramble command inputs: they must be ignored once accepted.
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_write = ~wr;
      bus_if.cmd_addr  = 32'hFFFF_FFF0;
      bus_if.cmd_wdata = 32'h5555_5555;
      if (addr[1:0] != 2'b00) begin
         check("unaligned_psel", 32'(bus_if.psel), 32'd0);
         check("unaligned_rsp_next_cycle", 32'(bus_if.rsp_valid), 32'd1);
         return;
      end
      check("setup_psel",    32'(bus_if.psel),    32'd1);
      check("setup_penable", 32'(bus_if.penable), 32'd0);
      check("setup_paddr",   bus_if.paddr,        addr);
      check("setup_pwrite",  32'(bus_if.pwrite),  32'(wr));
      check("setup_pwdata",  bus_if.pwdata,       wr ? wdata : 32'd0);
      @(negedge pclk);
      acc_cycles = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus_if.psel !== 1'b1) break;
         acc_cycles++;
         check("access_penable", 32'(bus_if.penable), 32'd1);
         check("access_paddr",   bus_if.paddr,        addr);
         check("access_pwdata",  bus_if.pwdata,       wr ? wdata : 32'd0);
         if (never_ready || k < waits) begin
            bus_if.pready  = 1'b0;
            bus_if.pslverr = 1'b1;
            bus_if.prdata  = 32'hBAD0_0000 | 32'(k);
         end else begin
            bus_if.pready  = 1'b1;
            bus_if.pslverr = err;
            bus_if.prdata  = rd;
         end
         @(negedge pclk);
      end
      bus_if.pready  = 1'b0;
      bus_if.pslverr = 1'b0;
      bus_if.prdata  = 32'd0;
      check("access_cycles", 32'(acc_cycles), never_ready ? 32'd4 : 32'(waits + 1));
      check("end_psel",      32'(bus_if.psel),      32'd0);
      check("end_penable",   32'(bus_if.penable),   32'd0);
      check("end_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
      check("end_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
   endtask

   initial begin
      presetn          = 1'b0;
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_write = 1'b0;
      bus_if.cmd_addr  = 32'd0;
      bus_if.cmd_wdata = 32'd0;
      bus_if.prdata    = 32'd0;
      bus_if.pready    = 1'b0;
      bus_if.pslverr   = 1'b0;
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      check("rst_psel",        32'(bus_if.psel),        32'd0);
      check("rst_penable",     32'(bus_if.penable),     32'd0);
      check("rst_pwrite",      32'(bus_if.pwrite),      32'd0);
      check("rst_paddr",       bus_if.paddr,            32'd0);
      check("rst_pwdata",      bus_if.pwdata,           32'd0);
      check("rst_rsp_valid",   32'(bus_if.rsp_valid),   32'd0);
      check("rst_rsp_rdata",   bus_if.rsp_rdata,        32'd0);
      check("rst_rsp_slverr",  32'(bus_if.rsp_slverr),  32'd0);
      check("rst_rsp_timeout", 32'(bus_if.rsp_timeout), 32'd0);
      check("rst_cmd_ready",   32'(bus_if.cmd_ready),   32'd1);
      presetn = 1'b1;
      @(negedge pclk);

      // wr, addr, wdata, waits, err, rdata, never_ready
      xfer(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0, 1'b0, 32'h0,         1'b0);
      xfer(1'b0, 32'h0000_0004, 32'h1234_5678, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
      @(negedge pclk);
      @(negedge pclk);
      check("hold_rsp_rdata",  bus_if.rsp_rdata,       32'hDEAD_BEEF);
      check("hold_rsp_valid",  32'(bus_if.rsp_valid),  32'd0);
      xfer(1'b0, 32'h0000_0020, 32'h0,         0, 1'b1, 32'hA5A5_A5A5, 1'b0);
      xfer(1'b1, 32'h0000_0100, 32'h0BAD_F00D, 3, 1'b0, 32'h0,         1'b0);
      xfer(1'b0, 32'h0000_0040, 32'h0,         0, 1'b0, 32'h0,         1'b1);
      @(negedge pclk);
      check("hold_rsp_timeout", 32'(bus_if.rsp_timeout), 32'd1);
      xfer(1'b0, 32'h0000_0044, 32'h0,         3, 1'b0, 32'h600D_CAFE, 1'b0);
      xfer(1'b1, 32'h0000_0006, 32'hCAFE_0006, 0, 1'b0, 32'h0,         1'b0);
      xfer(1'b0, 32'h0000_0003, 32'h0,         0, 1'b0, 32'h0,         1'b0);
      xfer(1'b1, 32'h0000_0008, 32'h8888_0008, 1, 1'b1, 32'h0,         1'b0);
      @(negedge pclk);

      // Reset during ACCESS: no response may follow.
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_write = 1'b1;
      bus_if.cmd_addr  = 32'h0000_0010;
      bus_if.cmd_wdata = 32'h1111_2222;
      @(negedge pclk);
      bus_if.cmd_valid = 1'b0;
      @(negedge pclk);
      check("pre_rst_penable", 32'(bus_if.penable), 32'd1);
      presetn = 1'b0;
      @(negedge pclk);
      check("midrst_psel",      32'(bus_if.psel),      32'd0);
      check("midrst_penable",   32'(bus_if.penable),   32'd0);
      check("midrst_paddr",     bus_if.paddr,          32'd0);
      check("midrst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      presetn = 1'b1;
      @(negedge pclk);
      check("post_rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
      check("post_rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);

      xfer(1'b1, 32'h0000_000C, 32'hFEED_0C0C, 0, 1'b0, 32'h0, 1'b0);
      repeat (3) @(negedge pclk);
      check("sb_empty",        32'(sb_q.size()), 32'd0);
      check("rsp_pulse_count", 32'(rsp_seen),    32'(rsp_expected));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck required finish");
      $fatal(1);
   end

endmodule
